// File: rtl/dp_operand_loader.sv
// -----------------------------------------------------------------------------
// dp_operand_loader
//
// Purpose:
//   Feeds the four-lane dot-product pipe and collects its results.
//   - Accepts (x, y) operand pairs over valid/ready.
//   - Packs four pairs into one bundle. A short final bundle (closed by
//     in_last) is zero-padded.
//   - Registers each bundle onto op_x1..4 / op_y1..4.
//   - Tracks every bundle through the fixed pipe latency.
//   - Captures dp_result into a small first-word-fall-through result FIFO.
//   - Credits admission so that every in-flight bundle already owns a FIFO
//     slot. The FIFO therefore cannot overflow.
//
// Parameters:
//   LATENCY     operand-register-to-result latency of the pipe (>= 1)
//   FIFO_DEPTH  result FIFO entries (>= 2, power of two)
//
// Ports:
//   clk                 clock
//   rst                 asynchronous reset, active low
//   in_valid/in_ready   operand pair handshake
//   in_x, in_y          operand pair
//   in_last             final pair of a vector, closes the current bundle
//   op_x1..4, op_y1..4  registered operands to the dot-product pipe
//   dp_result           pipe result (valid LATENCY cycles after an issue)
//   res_valid/res_ready result FIFO head handshake
//   res_data, res_last  FIFO head result and its end-of-vector flag
// -----------------------------------------------------------------------------
module dp_operand_loader #(
    parameter int LATENCY    = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_x,
    input  logic [31:0] in_y,
    input  logic        in_last,
    output logic [31:0] op_x1,
    output logic [31:0] op_x2,
    output logic [31:0] op_x3,
    output logic [31:0] op_x4,
    output logic [31:0] op_y1,
    output logic [31:0] op_y2,
    output logic [31:0] op_y3,
    output logic [31:0] op_y4,
    input  logic [31:0] dp_result,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic        res_last
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    logic [1:0]         r_lane_cnt;
    logic [31:0]        r_stg_x1, r_stg_x2, r_stg_x3;
    logic [31:0]        r_stg_y1, r_stg_y2, r_stg_y3;
    logic [31:0]        r_op_x1, r_op_x2, r_op_x3, r_op_x4;
    logic [31:0]        r_op_y1, r_op_y2, r_op_y3, r_op_y4;
    logic [LATENCY:0]   r_v;
    logic [LATENCY:0]   r_vl;
    logic [CW-1:0]      r_inflight;
    logic [CW-1:0]      r_count;
    logic [PW-1:0]      r_wptr;
    logic [PW-1:0]      r_rptr;
    logic [31:0]        r_mem [FIFO_DEPTH];
    logic [FIFO_DEPTH-1:0] r_lmem;

    // ------------------------------------------------------------------
    // Wires
    // ------------------------------------------------------------------
    logic               w_accept;
    logic               w_issue;
    logic               w_cap;
    logic               w_pop;
    logic [CW:0]        w_credit_used;
    logic [31:0]        w_nx1, w_nx2, w_nx3, w_nx4;
    logic [31:0]        w_ny1, w_ny2, w_ny3, w_ny4;

    // Each issued bundle is counted in r_inflight until capture, and then
    // in r_count until it is popped. The sum is the number of FIFO slots
    // already promised. in_ready depends on registers only.
    assign w_credit_used = {1'b0, r_inflight} + {1'b0, r_count};
    assign in_ready      = (w_credit_used < (CW+1)'(FIFO_DEPTH));

    assign w_accept = in_valid & in_ready;
    assign w_issue  = w_accept & ((r_lane_cnt == 2'd3) | in_last);
    assign w_cap    = r_v[LATENCY];
    assign w_pop    = res_ready & (r_count != '0);

    // ------------------------------------------------------------------
    // Bundle assembly at issue.
    // Lanes below lane_cnt come from staging. Lane lane_cnt+1 takes the
    // current pair. Lanes above it are zero, so stale staging contents
    // from an earlier, longer bundle never leak into a short bundle.
    // ------------------------------------------------------------------
    always_comb begin
        w_nx1 = r_stg_x1;
        w_ny1 = r_stg_y1;
        w_nx2 = r_stg_x2;
        w_ny2 = r_stg_y2;
        w_nx3 = r_stg_x3;
        w_ny3 = r_stg_y3;
        w_nx4 = '0;
        w_ny4 = '0;
        case (r_lane_cnt)
            2'd0: begin
                w_nx1 = in_x;  w_ny1 = in_y;
                w_nx2 = '0;    w_ny2 = '0;
                w_nx3 = '0;    w_ny3 = '0;
            end
            2'd1: begin
                w_nx2 = in_x;  w_ny2 = in_y;
                w_nx3 = '0;    w_ny3 = '0;
            end
            2'd2: begin
                w_nx3 = in_x;  w_ny3 = in_y;
            end
            default: begin
                w_nx4 = in_x;  w_ny4 = in_y;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Packing, operand registers and latency tracking
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lane_cnt <= '0;
            r_stg_x1   <= '0;
            r_stg_x2   <= '0;
            r_stg_x3   <= '0;
            r_stg_y1   <= '0;
            r_stg_y2   <= '0;
            r_stg_y3   <= '0;
            r_op_x1    <= '0;
            r_op_x2    <= '0;
            r_op_x3    <= '0;
            r_op_x4    <= '0;
            r_op_y1    <= '0;
            r_op_y2    <= '0;
            r_op_y3    <= '0;
            r_op_y4    <= '0;
            r_v        <= '0;
            r_vl       <= '0;
        end else begin
            if (w_accept && !w_issue) begin
                case (r_lane_cnt)
                    2'd0: begin r_stg_x1 <= in_x; r_stg_y1 <= in_y; end
                    2'd1: begin r_stg_x2 <= in_x; r_stg_y2 <= in_y; end
                    2'd2: begin r_stg_x3 <= in_x; r_stg_y3 <= in_y; end
                    default: ;
                endcase
            end

            if (w_issue) begin
                r_op_x1    <= w_nx1;
                r_op_x2    <= w_nx2;
                r_op_x3    <= w_nx3;
                r_op_x4    <= w_nx4;
                r_op_y1    <= w_ny1;
                r_op_y2    <= w_ny2;
                r_op_y3    <= w_ny3;
                r_op_y4    <= w_ny4;
                r_lane_cnt <= '0;
            end else if (w_accept) begin
                r_lane_cnt <= r_lane_cnt + 2'd1;
            end

            // v[0] is set at the issue edge. v[LATENCY] marks the cycle in
            // which dp_result carries that bundle's result.
            r_v  <= {r_v[LATENCY-1:0],  w_issue};
            r_vl <= {r_vl[LATENCY-1:0], w_issue & in_last};
        end
    end

    assign op_x1 = r_op_x1;
    assign op_x2 = r_op_x2;
    assign op_x3 = r_op_x3;
    assign op_x4 = r_op_x4;
    assign op_y1 = r_op_y1;
    assign op_y2 = r_op_y2;
    assign op_y3 = r_op_y3;
    assign op_y4 = r_op_y4;

    // ------------------------------------------------------------------
    // In-flight counter. Issue and capture in one cycle cancel out.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_issue, w_cap})
                2'b10:   r_inflight <= r_inflight + CW'(1);
                2'b01:   r_inflight <= r_inflight - CW'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Result FIFO (FWFT). Credit guarantees a free slot at every capture,
    // so the write side has no full check. The pointers wrap naturally
    // because FIFO_DEPTH is a power of two.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            r_lmem  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_cap) begin
                r_mem[r_wptr]  <= dp_result;
                r_lmem[r_wptr] <= r_vl[LATENCY];
                r_wptr         <= r_wptr + PW'(1);
            end
            if (w_pop) begin
                r_rptr <= r_rptr + PW'(1);
            end
            case ({w_cap, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign res_valid = (r_count != '0);
    assign res_data  = r_mem[r_rptr];
    assign res_last  = r_lmem[r_rptr];

endmodule

// File: tb/tb_dp_operand_loader.sv
// -----------------------------------------------------------------------------
// tb_dp_operand_loader
//
// Bench for dp_operand_loader.
// - A pipe stub computes a real-valued dot product of the registered operands
//   and delays it by LAT register stages.
// - The reference model works at the transaction level: a queue of expected
//   bundles and results, with credit = bundles issued but not yet popped.
// -----------------------------------------------------------------------------
module tb_dp_operand_loader;

    localparam int LAT   = 4;
    localparam int DEPTH = 4;

    localparam logic [31:0] F1 = 32'h3F800000;  // 1.0
    localparam logic [31:0] F2 = 32'h40000000;  // 2.0
    localparam logic [31:0] F3 = 32'h40400000;  // 3.0
    localparam logic [31:0] F4 = 32'h40800000;  // 4.0

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_x;
    logic [31:0] in_y;
    logic        in_last;
    logic [31:0] op_x [4];
    logic [31:0] op_y [4];
    logic [31:0] dp_result;
    logic        res_valid;
    logic        res_ready;
    logic [31:0] res_data;
    logic        res_last;

    always #5 clk = ~clk;

    dp_operand_loader #(.LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_x     (in_x),
        .in_y     (in_y),
        .in_last  (in_last),
        .op_x1    (op_x[0]),
        .op_x2    (op_x[1]),
        .op_x3    (op_x[2]),
        .op_x4    (op_x[3]),
        .op_y1    (op_y[0]),
        .op_y2    (op_y[1]),
        .op_y3    (op_y[2]),
        .op_y4    (op_y[3]),
        .dp_result(dp_result),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .res_last (res_last)
    );

    // ---------------- single-precision helpers (zero and normals only) -------
    function automatic real f2r(input logic [31:0] b);
        logic [63:0] d;
        logic [10:0] e;
        if (b[30:0] == 31'd0) return 0.0;
        e = 11'(b[30:23]) + 11'd896;
        d = {b[31], e, b[22:0], 29'd0};
        return $bitstoreal(d);
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        d = $realtobits(r);
        if (d[62:0] == 63'd0) return 32'd0;
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int2f(input int unsigned k);
        return r2f($itor(k));
    endfunction

    function automatic logic [31:0] dot4(input logic [3:0][31:0] x,
                                         input logic [3:0][31:0] y);
        real acc;
        acc = 0.0;
        for (int j = 0; j < 4; j++) acc = acc + f2r(x[j]) * f2r(y[j]);
        return r2f(acc);
    endfunction

    // ---------------- pipe stub: LAT register stages ----------------
    logic [31:0] pipe_s [LAT];
    always @(posedge clk) begin
        pipe_s[0] <= dot4({op_x[3], op_x[2], op_x[1], op_x[0]},
                          {op_y[3], op_y[2], op_y[1], op_y[0]});
        for (int i = 1; i < LAT; i++) pipe_s[i] <= pipe_s[i-1];
    end
    assign dp_result = pipe_s[LAT-1];

    // ---------------- reference model ----------------
    typedef struct {
        logic [31:0] res;
        logic        last;
        int          t;
    } exp_t;

    exp_t             q[$];
    int               cyc;
    int               m_cnt;
    logic [3:0][31:0] m_sx, m_sy;
    logic [3:0][31:0] iss_x, iss_y;
    logic             issued;
    int               n_issue;
    int               n_pop;
    logic [31:0]      pop_data;
    logic             pop_last;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, want %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // One clock cycle. Inputs must already be driven.
    // The model is updated from the pre-edge values seen at the negedge.
    task automatic step();
        logic exp_rv, acc, pop;
        exp_t e;
        @(negedge clk);
        exp_rv = (q.size() > 0) && (cyc >= q[0].t + LAT + 1);
        chk("in_ready", 32'(in_ready), 32'(q.size() < DEPTH));
        chk("res_valid", 32'(res_valid), 32'(exp_rv));
        acc = in_valid && (q.size() < DEPTH);
        pop = res_ready && exp_rv;
        if (pop) begin
            chk("res_data", res_data, q[0].res);
            chk("res_last", 32'(res_last), 32'(q[0].last));
            pop_data = res_data;
            pop_last = res_last;
            void'(q.pop_front());
            n_pop++;
        end
        issued = 1'b0;
        if (acc) begin
            m_sx[m_cnt] = in_x;
            m_sy[m_cnt] = in_y;
            if (m_cnt == 3 || in_last) begin
                for (int j = 0; j < 4; j++) begin
                    iss_x[j] = (j <= m_cnt) ? m_sx[j] : 32'd0;
                    iss_y[j] = (j <= m_cnt) ? m_sy[j] : 32'd0;
                end
                e.res  = dot4(iss_x, iss_y);
                e.last = in_last;
                e.t    = cyc + 1;
                q.push_back(e);
                issued = 1'b1;
                n_issue++;
                m_cnt = 0;
            end else begin
                m_cnt++;
            end
        end
        @(posedge clk);
        cyc++;
        #1;
        if (issued) begin
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("op_x%0d", j+1), op_x[j], iss_x[j]);
                chk($sformatf("op_y%0d", j+1), op_y[j], iss_y[j]);
            end
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [2:0]       n;
        logic             last;
        logic [3:0][31:0] x;    // [0] = first pair
        logic [3:0][31:0] y;
        logic [3:0][31:0] ox;   // expected op_x4..op_x1
        logic [3:0][31:0] oy;
        logic [31:0]      res;
    } vec_t;

    localparam int NV = 5;
    vec_t vt [NV];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int np;
        int n0;

        vt[0] = '{n:3'd4, last:1'b1, x:{F1,F1,F1,F1}, y:{F1,F1,F1,F1},
                  ox:{F1,F1,F1,F1}, oy:{F1,F1,F1,F1}, res:32'h40800000};
        vt[1] = '{n:3'd3, last:1'b1, x:{32'd0,F2,F2,F2}, y:{32'd0,F1,F1,F1},
                  ox:{32'd0,F2,F2,F2}, oy:{32'd0,F1,F1,F1}, res:32'h40C00000};
        vt[2] = '{n:3'd1, last:1'b1, x:{32'd0,32'd0,32'd0,F3}, y:{32'd0,32'd0,32'd0,F2},
                  ox:{32'd0,32'd0,32'd0,F3}, oy:{32'd0,32'd0,32'd0,F2}, res:32'h40C00000};
        vt[3] = '{n:3'd2, last:1'b1, x:{32'd0,32'd0,F2,F1}, y:{32'd0,32'd0,F4,F3},
                  ox:{32'd0,32'd0,F2,F1}, oy:{32'd0,32'd0,F4,F3}, res:32'h41300000};
        vt[4] = '{n:3'd4, last:1'b0, x:{F4,F3,F2,F1}, y:{F1,F1,F1,F1},
                  ox:{F4,F3,F2,F1}, oy:{F1,F1,F1,F1}, res:32'h41200000};

        in_valid  = 1'b0;
        in_x      = '0;
        in_y      = '0;
        in_last   = 1'b0;
        res_ready = 1'b0;
        cyc = 0; m_cnt = 0; n_issue = 0; n_pop = 0;
        m_sx = '0; m_sy = '0; iss_x = '0; iss_y = '0;
        pop_data = '0; pop_last = 1'b0; issued = 1'b0;

        // ---- reset values ----
        #1 rst = 1'b0;
        #2;
        chk("rst res_valid", 32'(res_valid), 32'd0);
        chk("rst res_data", res_data, 32'd0);
        chk("rst res_last", 32'(res_last), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk("rst op_x", op_x[j], 32'd0);
            chk("rst op_y", op_y[j], 32'd0);
        end
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;

        // ---- directed table ----
        res_ready = 1'b1;
        for (int v = 0; v < NV; v++) begin
            for (int k = 0; k < int'(vt[v].n); k++) begin
                in_valid = 1'b1;
                in_x     = vt[v].x[k];
                in_y     = vt[v].y[k];
                in_last  = vt[v].last && (k == int'(vt[v].n) - 1);
                step();
            end
            in_valid = 1'b0;
            in_last  = 1'b0;
            for (int j = 0; j < 4; j++) begin
                chk($sformatf("vec%0d op_x%0d", v, j+1), op_x[j], vt[v].ox[j]);
                chk($sformatf("vec%0d op_y%0d", v, j+1), op_y[j], vt[v].oy[j]);
            end
            np = n_pop;
            for (int w = 0; w < 20 && n_pop == np; w++) step();
            chk($sformatf("vec%0d result seen", v), 32'(n_pop != np), 32'd1);
            if (n_pop != np) begin
                chk($sformatf("vec%0d res_data", v), pop_data, vt[v].res);
                chk($sformatf("vec%0d res_last", v), 32'(pop_last), 32'(vt[v].last));
            end
        end

        // ---- consumer stalled: credit must stop at DEPTH bundles ----
        res_ready = 1'b0;
        n0 = n_issue;
        in_valid = 1'b1;
        in_last  = 1'b0;
        for (int c = 0; c < 40; c++) begin
            in_x = int2f($urandom_range(0, 255));
            in_y = int2f($urandom_range(0, 255));
            step();
        end
        chk("stall issue count", 32'(n_issue - n0), 32'(DEPTH));
        chk("stall in_ready", 32'(in_ready), 32'd0);
        in_valid  = 1'b0;
        res_ready = 1'b1;
        for (int w = 0; w < 60 && q.size() > 0; w++) step();
        chk("stall drained", 32'(q.size()), 32'd0);
        step();
        chk("in_ready after drain", 32'(in_ready), 32'd1);

        // ---- single-pair bundles at full rate ----
        // Captures and pops collide and the pointers wrap many times.
        in_valid = 1'b1;
        in_last  = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in_x = int2f($urandom_range(0, 255));
            in_y = int2f($urandom_range(0, 255));
            res_ready = (c % 5) != 4;
            step();
        end
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        for (int w = 0; w < 60 && q.size() > 0; w++) step();
        chk("burst drained", 32'(q.size()), 32'd0);

        // ---- reset with 2 results in flight and 2 in the FIFO ----
        res_ready = 1'b0;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        for (int c = 0; c < 4; c++) begin
            in_x = int2f(32'(c + 1));
            in_y = F2;
            step();
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        repeat (3) step();
        chk("pre-reset res_valid", 32'(res_valid), 32'd1);
        rst = 1'b0;
        #1;
        chk("mid-reset res_valid", 32'(res_valid), 32'd0);
        chk("mid-reset in_ready", 32'(in_ready), 32'd1);
        for (int j = 0; j < 4; j++) begin
            chk("mid-reset op_x", op_x[j], 32'd0);
            chk("mid-reset op_y", op_y[j], 32'd0);
        end
        q.delete();
        m_cnt = 0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        res_ready = 1'b1;
        repeat (12) step();

        // ---- randomized traffic ----
        for (int c = 0; c < 2000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            in_last   = ($urandom_range(0, 4) == 0);
            in_x      = int2f($urandom_range(0, 255));
            in_y      = int2f($urandom_range(0, 255));
            res_ready = ($urandom_range(0, 2) != 0);
            step();
        end
        // Close any partial bundle, then drain.
        in_valid = 1'b1;
        in_last  = 1'b1;
        in_x     = F1;
        in_y     = F1;
        for (int w = 0; w < 20 && m_cnt != 0; w++) step();
        in_valid  = 1'b0;
        in_last   = 1'b0;
        res_ready = 1'b1;
        for (int w = 0; w < 80 && q.size() > 0; w++) step();
        chk("random drained", 32'(q.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
